// File: rtl/pio_pkg.sv
// -----------------------------------------------------------------------------
// pio_pkg
// Constants shared by the DE2 parallel I/O peripherals (input and output PIO).
//   ADDR_*  : Avalon-MM register word addresses on the 2-bit address bus
//   EDGE_*  : encodings for the EDGE_TYPE parameter of the input PIO
//   DATA_W  : Avalon data bus width
// -----------------------------------------------------------------------------
package pio_pkg;

   localparam int unsigned DATA_W = 32'd32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_UNUSED  = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int unsigned EDGE_RISING  = 32'd0;
   localparam int unsigned EDGE_FALLING = 32'd1;
   localparam int unsigned EDGE_ANY     = 32'd2;

endpackage

// File: rtl/de2_pio_edge_in_if.sv
// -----------------------------------------------------------------------------
// de2_pio_edge_in_if
// Avalon-MM slave bus of the input PIO, plus its interrupt line.
//   address    : register select            (master -> slave)
//   chipselect : slave select               (master -> slave)
//   write_n    : active-low write strobe    (master -> slave)
//   writedata  : write data                 (master -> slave)
//   readdata   : read data, zero wait state (slave -> master)
//   irq        : level interrupt            (slave -> master)
// -----------------------------------------------------------------------------
interface de2_pio_edge_in_if;
   import pio_pkg::*;

   logic [1:0]        address;
   logic              chipselect;
   logic              write_n;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] readdata;
   logic              irq;

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

endinterface

// File: rtl/pio_sync_bus.sv
// -----------------------------------------------------------------------------
// pio_sync_bus
// Multi-flop synchroniser for a bus of independent asynchronous inputs.
// Each bit is synchronised on its own; no cross-bit coherence is implied.
//   clk      : destination clock
//   reset_n  : asynchronous active-low reset, all stages clear to 0
//   async_i  : asynchronous inputs
//   sync_o   : inputs delayed by SYNC_STAGES clk edges
// -----------------------------------------------------------------------------
module pio_sync_bus #(
   parameter int unsigned WIDTH       = 32'd4,
   parameter int unsigned SYNC_STAGES = 32'd2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];

   // Synchroniser chain: stage 0 samples the pins, later stages shift along.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= async_i;
         for (int i = 1; i < int'(SYNC_STAGES); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign sync_o = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/de2_pio_edge_in.sv
// -----------------------------------------------------------------------------
// de2_pio_edge_in
// Avalon-MM input PIO for the DE2 KEY/SW inputs with edge capture and IRQ.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata,
//              readdata, irq)
//   in_port  : asynchronous board inputs
// Register map: 0 DATA (RO), 1 reads 0, 2 IRQMASK (RW), 3 EDGECAP (W1C).
// -----------------------------------------------------------------------------
module de2_pio_edge_in
   import pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 32'd4,
   parameter int unsigned SYNC_STAGES = 32'd2,
   parameter int unsigned EDGE_TYPE   = EDGE_FALLING,
   parameter logic [31:0] IRQ_RESET   = 32'd0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   de2_pio_edge_in_if.slave        bus,
   input  logic [WIDTH-1:0]        in_port
);

   // Warm-up covers the synchroniser fill plus the delayed-copy stage, so the
   // first real sample after reset never looks like an edge against zeros.
   localparam int unsigned  WARM_CYCLES = SYNC_STAGES + 32'd1;
   localparam int unsigned  CNT_W       = $clog2(WARM_CYCLES + 32'd1);
   localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARM_CYCLES);

   logic [WIDTH-1:0]  sync_q;
   logic [WIDTH-1:0]  sync_dly_q;
   logic [CNT_W-1:0]  warm_cnt_q;
   logic [CNT_W-1:0]  warm_cnt_d;
   logic [WIDTH-1:0]  edgecap_q;
   logic [WIDTH-1:0]  edgecap_d;
   logic [WIDTH-1:0]  irqmask_q;
   logic [WIDTH-1:0]  irqmask_d;

   logic              warm_done_s;
   logic              wr_s;
   logic [WIDTH-1:0]  edge_raw_s;
   logic [WIDTH-1:0]  edge_ev_s;
   logic [WIDTH-1:0]  clr_s;
   logic [DATA_W-1:0] rdata_s;
   logic              unused_wdata_s;

   pio_sync_bus #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .async_i (in_port),
      .sync_o  (sync_q)
   );

   // Only writedata[WIDTH-1:0] carries register bits; the rest is ignored.
   assign unused_wdata_s = ^bus.writedata;

   assign warm_done_s = (warm_cnt_q == WARM_LAST);
   assign wr_s        = bus.chipselect & ~bus.write_n;

   // Warm-up counter next state: count up once, then hold until next reset.
   always_comb begin
      warm_cnt_d = warm_cnt_q;
      if (warm_done_s) begin
         warm_cnt_d = warm_cnt_q;
      end else begin
         warm_cnt_d = warm_cnt_q + CNT_W'(1);
      end
   end

   // Per-bit edge event selected by EDGE_TYPE, gated off during warm-up.
   always_comb begin
      edge_raw_s = '0;
      case (EDGE_TYPE)
         EDGE_RISING:  edge_raw_s = sync_q & ~sync_dly_q;
         EDGE_FALLING: edge_raw_s = ~sync_q & sync_dly_q;
         EDGE_ANY:     edge_raw_s = sync_q ^ sync_dly_q;
         default:      edge_raw_s = '0;
      endcase
      if (warm_done_s) begin
         edge_ev_s = edge_raw_s;
      end else begin
         edge_ev_s = '0;
      end
   end

   // EDGECAP / IRQMASK next state; a set on the same cycle as a clear wins.
   always_comb begin
      clr_s     = '0;
      irqmask_d = irqmask_q;
      if (wr_s && (bus.address == ADDR_EDGECAP)) begin
         clr_s = bus.writedata[WIDTH-1:0];
      end else begin
         clr_s = '0;
      end
      if (wr_s && (bus.address == ADDR_IRQMASK)) begin
         irqmask_d = bus.writedata[WIDTH-1:0];
      end else begin
         irqmask_d = irqmask_q;
      end
      edgecap_d = (edgecap_q & ~clr_s) | edge_ev_s;
   end

   // State registers; the delayed copy tracks sync_q even during warm-up.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_dly_q <= '0;
         warm_cnt_q <= '0;
         edgecap_q  <= '0;
         irqmask_q  <= IRQ_RESET[WIDTH-1:0];
      end else begin
         sync_dly_q <= sync_q;
         warm_cnt_q <= warm_cnt_d;
         edgecap_q  <= edgecap_d;
         irqmask_q  <= irqmask_d;
      end
   end

   // Zero-wait-state read mux; deselected or unmapped reads return 0.
   always_comb begin
      rdata_s = '0;
      if (bus.chipselect) begin
         case (bus.address)
            ADDR_DATA:    rdata_s[WIDTH-1:0] = sync_q;
            ADDR_UNUSED:  rdata_s = '0;
            ADDR_IRQMASK: rdata_s[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: rdata_s[WIDTH-1:0] = edgecap_q;
            default:      rdata_s = '0;
         endcase
      end else begin
         rdata_s = '0;
      end
   end

   assign bus.readdata = rdata_s;
   assign bus.irq      = |(edgecap_q & irqmask_q);

endmodule
